// File: rtl/sram_fifo_pkg.sv
// Shared defaults for the SRAM-backed show-ahead FIFO.
package sram_fifo_pkg;
  localparam int SRAM_FIFO_DEF_WIDTH = 64;
  localparam int SRAM_FIFO_DEF_SIZE  = 8;
endpackage

// File: rtl/sram_fifo_sram_1r1w.sv
// One-read/one-write SRAM, registered read, same-address write-to-read bypass.
module sram_1r1w #(
  parameter int DATA_WIDTH = 64,
  parameter int SIZE       = 8,
  localparam int AW        = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  i_rd_en,
  input  logic [AW-1:0]         i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  input  logic                  i_wr_en,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data
);
  logic [DATA_WIDTH-1:0] r_mem [SIZE];
  logic [DATA_WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    // Bypass lets a write into the slot being read show up on the same edge.
    if (i_rd_en)
      r_rd_data <= (i_wr_en && (i_wr_addr == i_rd_addr)) ? i_wr_data : r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/sram_fifo.sv
// Show-ahead FIFO controller over a single sram_1r1w; head entry is always on
// dequeue_value while empty is low.
module sram_fifo
  import sram_fifo_pkg::*;
#(
  parameter int WIDTH                  = SRAM_FIFO_DEF_WIDTH,
  parameter int SIZE                   = SRAM_FIFO_DEF_SIZE,
  parameter int ALMOST_FULL_THRESHOLD  = SIZE,
  parameter int ALMOST_EMPTY_THRESHOLD = 1,
  parameter bit STRICT_PROTOCOL        = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_en,
  input  logic             enqueue_en,
  input  logic [WIDTH-1:0] enqueue_value,
  input  logic             dequeue_en,
  output logic [WIDTH-1:0] dequeue_value,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty
);
  localparam int ADDR_WIDTH = $clog2(SIZE);
  localparam logic [ADDR_WIDTH:0] SIZE_CNT = (ADDR_WIDTH+1)'(SIZE);

  logic [ADDR_WIDTH-1:0] r_rd_ptr, r_wr_ptr, w_rd_addr;
  logic [ADDR_WIDTH:0]   r_count, w_count_nxt;
  logic                  r_full, r_empty, r_almost_full, r_almost_empty;
  logic                  w_clr, w_do_enq, w_do_deq;

  assign w_clr    = reset || flush_en;
  assign w_do_enq = enqueue_en && (!r_full || dequeue_en) && !w_clr;
  assign w_do_deq = dequeue_en && !r_empty && !w_clr;

  // Read the next head every cycle so it is registered in time to be shown.
  assign w_rd_addr   = r_rd_ptr + ADDR_WIDTH'(w_do_deq);
  assign w_count_nxt = w_clr ? '0
                     : r_count + (ADDR_WIDTH+1)'(w_do_enq) - (ADDR_WIDTH+1)'(w_do_deq);

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= w_rd_addr;
      r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(w_do_enq);
      r_count  <= w_count_nxt;
    end
    // Flags follow next-state count; a clear drives it to zero, giving reset values.
    r_empty        <= (w_count_nxt == '0);
    r_full         <= (w_count_nxt == SIZE_CNT);
    r_almost_full  <= (int'(w_count_nxt) >= ALMOST_FULL_THRESHOLD);
    r_almost_empty <= (int'(w_count_nxt) <= ALMOST_EMPTY_THRESHOLD);
  end

  sram_1r1w #(.DATA_WIDTH(WIDTH), .SIZE(SIZE)) u_sram (
    .clk       (clk),
    .i_rd_en   (1'b1),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (dequeue_value),
    .i_wr_en   (w_do_enq),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (enqueue_value)
  );

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (STRICT_PROTOCOL) begin
        assert (!(enqueue_en && r_full && !dequeue_en))
          else begin $error("sram_fifo: enqueue while full"); $finish; end
        assert (!(dequeue_en && r_empty))
          else begin $error("sram_fifo: dequeue while empty"); $finish; end
      end
      assert (r_count <= SIZE_CNT)
        else begin $error("sram_fifo: count exceeds SIZE"); $finish; end
    end
  end
`endif
endmodule

// File: tb/tb_sram_fifo.sv
// Directed bench: default-threshold FIFO plus a 6/2-threshold twin on shared stimulus.
module tb_sram_fifo;
  logic        clk = 1'b0;
  logic        reset, flush_en, enqueue_en, dequeue_en;
  logic [63:0] enqueue_value;
  logic [63:0] dq_a, dq_b;
  logic        full_a, empty_a, af_a, ae_a;
  logic        full_b, empty_b, af_b, ae_b;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  sram_fifo #(.WIDTH(64), .SIZE(8), .STRICT_PROTOCOL(1'b0)) dut_a (
    .clk(clk), .reset(reset), .flush_en(flush_en), .enqueue_en(enqueue_en),
    .enqueue_value(enqueue_value), .dequeue_en(dequeue_en), .dequeue_value(dq_a),
    .full(full_a), .empty(empty_a), .almost_full(af_a), .almost_empty(ae_a));

  sram_fifo #(.WIDTH(64), .SIZE(8), .ALMOST_FULL_THRESHOLD(6),
              .ALMOST_EMPTY_THRESHOLD(2), .STRICT_PROTOCOL(1'b0)) dut_b (
    .clk(clk), .reset(reset), .flush_en(flush_en), .enqueue_en(enqueue_en),
    .enqueue_value(enqueue_value), .dequeue_en(dequeue_en), .dequeue_value(dq_b),
    .full(full_b), .empty(empty_b), .almost_full(af_b), .almost_empty(ae_b));

  typedef struct {
    logic        enq;
    logic        deq;
    logic [63:0] data;
    int          cnt;
    logic        chk_val;
    logic [63:0] val;
  } vec_t;

  vec_t vecs[28];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic fl, input logic enq,
                      input logic deq, input logic [63:0] data);
    reset = rst; flush_en = fl; enqueue_en = enq; dequeue_en = deq; enqueue_value = data;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input int cnt);
    chk({tag, " empty"},  64'(empty_a), 64'(cnt == 0));
    chk({tag, " full"},   64'(full_a),  64'(cnt == 8));
    chk({tag, " a_full"}, 64'(af_a),    64'(cnt >= 8));
    chk({tag, " a_emp"},  64'(ae_a),    64'(cnt <= 1));
    chk({tag, " a_full6"},64'(af_b),    64'(cnt >= 6));
    chk({tag, " a_emp2"}, 64'(ae_b),    64'(cnt <= 2));
  endtask

  initial begin
    // enq, deq, data, count after edge, check value, expected head
    vecs[0]  = '{1'b1, 1'b0, 64'hA5, 1, 1'b1, 64'hA5};
    vecs[1]  = '{1'b0, 1'b1, 64'h0,  0, 1'b0, 64'h0};
    for (int i = 0; i < 8; i++)
      vecs[2+i] = '{1'b1, 1'b0, 64'(i+1), i+1, 1'b1, 64'h1};
    vecs[10] = '{1'b1, 1'b0, 64'h9,  8, 1'b1, 64'h1};   // dropped while full
    vecs[11] = '{1'b1, 1'b1, 64'h99, 8, 1'b1, 64'h2};
    vecs[12] = '{1'b1, 1'b1, 64'h9A, 8, 1'b1, 64'h3};
    vecs[13] = '{1'b1, 1'b1, 64'h9B, 8, 1'b1, 64'h4};
    vecs[14] = '{1'b0, 1'b1, 64'h0,  7, 1'b1, 64'h5};
    vecs[15] = '{1'b0, 1'b1, 64'h0,  6, 1'b1, 64'h6};
    vecs[16] = '{1'b0, 1'b1, 64'h0,  5, 1'b1, 64'h7};
    vecs[17] = '{1'b0, 1'b1, 64'h0,  4, 1'b1, 64'h8};
    vecs[18] = '{1'b0, 1'b1, 64'h0,  3, 1'b1, 64'h99};
    vecs[19] = '{1'b0, 1'b1, 64'h0,  2, 1'b1, 64'h9A};
    vecs[20] = '{1'b0, 1'b1, 64'h0,  1, 1'b1, 64'h9B};
    vecs[21] = '{1'b0, 1'b1, 64'h0,  0, 1'b0, 64'h0};
    vecs[22] = '{1'b1, 1'b1, 64'h42, 1, 1'b1, 64'h42};  // both on empty: enqueue only
    vecs[23] = '{1'b0, 1'b1, 64'h0,  0, 1'b0, 64'h0};
    vecs[24] = '{1'b0, 1'b1, 64'h0,  0, 1'b0, 64'h0};   // dequeue on empty ignored
    vecs[25] = '{1'b1, 1'b0, 64'h55, 1, 1'b1, 64'h55};
    vecs[26] = '{1'b1, 1'b1, 64'h56, 1, 1'b1, 64'h56};  // count 1, write into next head
    vecs[27] = '{1'b0, 1'b1, 64'h0,  0, 1'b0, 64'h0};

    reset = 1'b1; flush_en = 1'b0; enqueue_en = 1'b0; dequeue_en = 1'b0; enqueue_value = '0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 64'hEE);
    chk_flags("reset", 0);
    chk("reset full_b", 64'(full_b), 64'h0);

    for (int i = 0; i < 28; i++) begin
      step(1'b0, 1'b0, vecs[i].enq, vecs[i].deq, vecs[i].data);
      chk_flags($sformatf("vec%0d", i), vecs[i].cnt);
      if (vecs[i].chk_val) begin
        chk($sformatf("vec%0d head", i), dq_a, vecs[i].val);
        chk($sformatf("vec%0d head_b", i), dq_b, vecs[i].val);
      end
    end

    // Flush with a concurrent enqueue discards everything, including the new entry.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 64'(16'h60 + i));
    chk_flags("load5", 5);
    chk("load5 head", dq_a, 64'h60);
    step(1'b0, 1'b1, 1'b1, 1'b0, 64'h77);
    chk_flags("flush", 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 64'h11);
    chk_flags("post_flush", 1);
    chk("post_flush head", dq_a, 64'h11);
    step(1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
    chk_flags("post_flush_deq", 0);

    // Reset mid-traffic behaves the same way.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 64'(16'h30 + i));
    chk("load3 head", dq_a, 64'h30);
    step(1'b1, 1'b0, 1'b1, 1'b1, 64'h33);
    chk_flags("mid_reset", 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 64'h22);
    chk_flags("post_reset", 1);
    chk("post_reset head", dq_a, 64'h22);
    step(1'b0, 1'b0, 1'b1, 1'b0, 64'h23);
    chk("post_reset head2", dq_a, 64'h22);
    step(1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
    chk("post_reset pop", dq_a, 64'h23);
    chk_flags("post_reset_pop", 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
